// File: rtl/uart_tx_engine.sv
// uart_tx_engine: drains the TX FIFO and shifts each word out on tx, LSB first,
// framed as start | data | [parity] | stop(s). Idle line is high.
// Optional parity bit: define UART_TX_PARITY_EN (PARITY_ODD picks the sense).
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_engine: illegal parameter set");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign bit_end    = (clk_cnt_q == CntLast);
  assign fifo_rd_en = (state_q == StFetch);
  assign busy       = (state_q != StIdle);
  assign tx         = tx_q;

  // Next-state, counter and shift-register update; tx_done fires on the last stop clock.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tx_done   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        // FIFO data is valid the cycle after the pop.
        shreg_d   = fifo_data;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d     = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
        state_d   = StStart;
      end
      StStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shreg_d   = shreg_q >> 1;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == StopLast) begin
            bit_cnt_d = '0;
            tx_done   = 1'b1;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the state being entered so tx changes on the same edge as the state.
  always_comb begin
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and registered tx line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine with CLKS_PER_BIT=4.
// dut: STOP_BITS=1, even parity; dut2: STOP_BITS=2, odd parity.
`timescale 1ns/1ps
module tb_uart_tx_engine;

  localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;  // even parity of data
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en, tx, busy, tx_done;
  logic       fifo2_empty;
  logic [7:0] fifo2_data;
  logic       fifo2_rd_en, tx2, busy2, tx_done2;

  logic [7:0] mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_pulses = 0;
  int         rd2_pulses = 0;
  int         underflows = 0;

  logic [7:0] exp_q [$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo2_data = 8'h81;

  uart_tx_engine #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(Cpb),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  uart_tx_engine #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(Cpb),
    .STOP_BITS   (2),
    .PARITY_ODD  (1)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo2_empty),
    .fifo_data (fifo2_data),
    .fifo_rd_en(fifo2_rd_en),
    .tx        (tx2),
    .busy      (busy2),
    .tx_done   (tx_done2)
  );

  // FIFO model: registered read data, valid the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) underflows++;
      fifo_data <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
      rd_pulses++;
    end
    if (fifo2_rd_en) rd2_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit score);
    mem[wr_ptr % 16] = d;
    wr_ptr++;
    if (score) exp_q.push_back(d);
  endtask

  // Expected line level per bit slot: start, data LSB first, [parity], stop(s).
  function automatic logic [11:0] model_line(input logic [7:0] d, input logic par);
    logic [11:0] l;
    l    = '1;
    l[0] = 1'b0;
    for (int i = 0; i < 8; i++) l[i+1] = d[i];
    if (ParBits == 1) l[9] = par;
    return l;
  endfunction

  // Waits for the start bit, then checks every clock of one frame against the model.
  task automatic rx_frame(input int sel, input int exp_wait, input logic par, input int stops);
    int          waited   = 0;
    int          nbits    = 1 + 8 + ParBits + stops;
    int          nclk     = nbits * Cpb;
    int          done_at  = -1;
    int          done_cnt = 0;
    int          busy_bad = 0;
    logic [7:0]  d;
    logic [7:0]  got      = '0;
    logic [11:0] line;
    logic [Cpb-1:0] smp;
    logic        tx_s;
    tx_s = sel ? tx2 : tx;
    while (tx_s === 1'b1 && waited < 400) begin
      tick();
      waited++;
      tx_s = sel ? tx2 : tx;
    end
    check($sformatf("start_latency%0d", sel), waited, exp_wait);
    if (tx_s !== 1'b0) return;
    d    = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    line = model_line(d, par);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < Cpb; c++) begin
        if (b != 0 || c != 0) tick();
        tx_s   = sel ? tx2 : tx;
        smp[c] = tx_s;
        if ((sel ? tx_done2 : tx_done) === 1'b1) begin
          done_cnt++;
          done_at = b * Cpb + c + 1;
        end
        if ((sel ? busy2 : busy) !== 1'b1) busy_bad++;
        if (c == Cpb / 2 && b >= 1 && b <= 8) got[b-1] = tx_s;
      end
      check($sformatf("d%0d_%02h_bit%0d", sel, d, b), smp, {Cpb{line[b]}});
    end
    check($sformatf("d%0d_data", sel), got, d);
    check($sformatf("d%0d_busy_in_frame", sel), busy_bad, 0);
    check($sformatf("d%0d_tx_done_clock", sel), done_at, nclk);
    check($sformatf("d%0d_tx_done_count", sel), done_cnt, 1);
    tick();
    check($sformatf("d%0d_busy_after", sel), sel ? busy2 : busy, 0);
    check($sformatf("d%0d_tx_after", sel), sel ? tx2 : tx, 1);
  endtask

  initial begin
    vec_t vecs [5];
    int   rd0;
    int   bad;
    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h07, par: 1'b1};
    vecs[2] = '{data: 8'hFF, par: 1'b0};
    vecs[3] = '{data: 8'h3C, par: 1'b0};
    vecs[4] = '{data: 8'h01, par: 1'b1};

    // Reset state and quiet line with an empty FIFO.
    rst         = 1'b1;
    fifo2_empty = 1'b1;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx2", tx2, 1);
    check("rst_busy2", busy2, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("idle_line_bad_clocks", bad, 0);
    check("idle_rd_pulses", rd_pulses, 0);

    // Single frames from the vector table.
    foreach (vecs[i]) begin
      repeat (5) tick();
      rd0 = rd_pulses;
      push(vecs[i].data, 1'b1);
      rx_frame(0, 3, vecs[i].par, 1);
      check($sformatf("rd_pulses_%02h", vecs[i].data), rd_pulses - rd0, 1);
    end

    // Back-to-back frames: 3 idle-high clocks between stop and next start.
    repeat (5) tick();
    rd0 = rd_pulses;
    push(8'h00, 1'b1);
    push(8'hFF, 1'b1);
    push(8'h3C, 1'b1);
    rx_frame(0, 3, 1'b0, 1);
    rx_frame(0, 3, 1'b0, 1);
    rx_frame(0, 3, 1'b0, 1);
    repeat (10) tick();
    check("b2b_rd_pulses", rd_pulses - rd0, 3);
    check("b2b_idle_busy", busy, 0);

    // Two stop bits, odd parity on dut2; empty is low for exactly one sampling edge.
    repeat (5) tick();
    rd0 = rd2_pulses;
    exp_q.push_back(8'h81);
    fifo2_empty = 1'b0;
    tick();
    fifo2_empty = 1'b1;
    rx_frame(1, 2, 1'b1, 2);
    repeat (10) tick();
    check("stop2_rd_pulses", rd2_pulses - rd0, 1);

    // Reset in the middle of data bit 3 of 0x55.
    repeat (5) tick();
    rd0 = rd_pulses;
    push(8'h55, 1'b0);
    repeat (3) tick();
    check("mid_start_bit", tx, 0);
    repeat (16) tick();
    check("mid_bit3_level", tx, 0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd0 = rd_pulses;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
    end
    check("post_rst_bad_clocks", bad, 0);
    check("post_rst_rd_pulses", rd_pulses - rd0, 0);
    check("underflows", underflows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
